// File: rtl/posit_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : posit_mac_sequencer
// Brief    : Drives a bit-serial FP16 x posit(es=0) multiplier: programs the
//            precision, streams each weight MSB-first and returns the product.
// Revision : 1.0
// ============================================================================
module posit_mac_sequencer #(
  parameter int ACT_WIDTH         = 16,
  parameter int DEFAULT_PRECISION = 8,
  parameter int TIMEOUT           = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [3:0]           cfg_precision,
  output logic                 cfg_ready,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [7:0]           in_weight,
  output logic [ACT_WIDTH-1:0] mul_act,
  output logic                 mul_w,
  output logic                 mul_valid,
  output logic                 mul_set,
  output logic [3:0]           mul_precision,
  input  logic                 mul_sign,
  input  logic [4:0]           mul_exp,
  input  logic [13:0]          mul_mantissa,
  input  logic                 mul_done,
  input  logic                 mul_zero,
  input  logic                 mul_nar,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [4:0]           out_exp,
  output logic [13:0]          out_mantissa,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic                 out_err,
  output logic                 busy
);

  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] C_WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0] C_DEF_PREC = 4'(DEFAULT_PRECISION);

  typedef enum logic [2:0] {
    S_CONFIG = 3'd0,
    S_IDLE   = 3'd1,
    S_STREAM = 3'd2,
    S_GAP    = 3'd3,
    S_WAIT   = 3'd4,
    S_OUTPUT = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             prec_q, prec_d;
  logic [ACT_WIDTH-1:0]   act_q, act_d;
  logic [7:0]             weight_q, weight_d;
  logic [2:0]             k_q, k_d;
  logic [TW-1:0]          wcnt_q, wcnt_d;
  logic                   sign_q, sign_d;
  logic [4:0]             exp_q, exp_d;
  logic [13:0]            mant_q, mant_d;
  logic                   zero_q, zero_d;
  logic                   nar_q, nar_d;
  logic                   err_q, err_d;

  logic [3:0]             w_cfg_clamped;
  logic [3:0]             w_prec_m1;

  always_comb begin
    w_cfg_clamped = cfg_precision;
    if (cfg_precision < 4'd2) begin
      w_cfg_clamped = 4'd2;
    end else if (cfg_precision > 4'd8) begin
      w_cfg_clamped = 4'd8;
    end
  end

  assign w_prec_m1 = prec_q - 4'd1;

  always_comb begin
    state_d  = state_q;
    prec_d   = prec_q;
    act_d    = act_q;
    weight_d = weight_q;
    k_d      = k_q;
    wcnt_d   = wcnt_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    zero_d   = zero_q;
    nar_d    = nar_q;
    err_d    = err_q;
    case (state_q)
      S_CONFIG: state_d = S_IDLE;
      S_IDLE: begin
        if (cfg_valid) begin
          prec_d  = w_cfg_clamped;
          state_d = S_CONFIG;
        end else if (in_valid) begin
          act_d    = in_act;
          weight_d = in_weight;
          k_d      = w_prec_m1[2:0];
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (k_q == 3'd0) begin
          state_d = S_GAP;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      S_GAP: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // mul_done is only trusted here; a level left over from STREAM is ignored.
        if (mul_done) begin
          sign_d  = mul_sign;
          exp_d   = mul_exp;
          mant_d  = mul_mantissa;
          zero_d  = mul_zero;
          nar_d   = mul_nar;
          err_d   = 1'b0;
          state_d = S_OUTPUT;
        end else if (wcnt_q == C_WAIT_LAST) begin
          sign_d  = 1'b0;
          exp_d   = '0;
          mant_d  = '0;
          zero_d  = 1'b0;
          nar_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_OUTPUT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_CONFIG;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_CONFIG;
      prec_q   <= C_DEF_PREC;
      act_q    <= '0;
      weight_q <= '0;
      k_q      <= '0;
      wcnt_q   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      zero_q   <= 1'b0;
      nar_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prec_q   <= prec_d;
      act_q    <= act_d;
      weight_q <= weight_d;
      k_q      <= k_d;
      wcnt_q   <= wcnt_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      zero_q   <= zero_d;
      nar_q    <= nar_d;
      err_q    <= err_d;
    end
  end

  // The reset state is CONFIG, so strobe-like outputs are masked while rst is held.
  assign mul_set       = (state_q == S_CONFIG) & ~rst;
  assign busy          = (state_q != S_IDLE) & ~rst;
  assign mul_valid     = (state_q == S_STREAM);
  assign mul_w         = mul_valid ? weight_q[k_q] : 1'b0;
  assign mul_act       = act_q;
  assign mul_precision = prec_q;
  assign cfg_ready     = (state_q == S_IDLE);
  assign in_ready      = (state_q == S_IDLE) & ~cfg_valid;
  assign out_valid     = (state_q == S_OUTPUT);
  assign out_sign      = sign_q;
  assign out_exp       = exp_q;
  assign out_mantissa  = mant_q;
  assign out_zero      = zero_q;
  assign out_nar       = nar_q;
  assign out_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_posit_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_mac_sequencer
// Brief    : Directed self-checking bench for posit_mac_sequencer.
// Revision : 1.0
// ============================================================================
module tb_posit_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [3:0]  cfg_precision;
  logic        cfg_ready;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_act;
  logic [7:0]  in_weight;
  logic [15:0] mul_act;
  logic        mul_w;
  logic        mul_valid;
  logic        mul_set;
  logic [3:0]  mul_precision;
  logic        mul_sign;
  logic [4:0]  mul_exp;
  logic [13:0] mul_mantissa;
  logic        mul_done = 1'b0;
  logic        mul_zero;
  logic        mul_nar;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [4:0]  out_exp;
  logic [13:0] out_mantissa;
  logic        out_zero;
  logic        out_nar;
  logic        out_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic model_en  = 1'b1;
  logic prev_mv   = 1'b0;
  logic fall_seen = 1'b0;
  int   overlap   = 0;

  posit_mac_sequencer #(
    .ACT_WIDTH(16),
    .DEFAULT_PRECISION(8),
    .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_precision(cfg_precision), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_weight(in_weight),
    .mul_act(mul_act), .mul_w(mul_w), .mul_valid(mul_valid), .mul_set(mul_set),
    .mul_precision(mul_precision), .mul_sign(mul_sign), .mul_exp(mul_exp),
    .mul_mantissa(mul_mantissa), .mul_done(mul_done), .mul_zero(mul_zero),
    .mul_nar(mul_nar), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mantissa(out_mantissa),
    .out_zero(out_zero), .out_nar(out_nar), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: one-cycle done pulse in the cycle after the stream ends.
  always @(posedge clk) begin
    #2;
    mul_done  = model_en && fall_seen;
    fall_seen = prev_mv && !mul_valid;
    prev_mv   = mul_valid;
    if (mul_set && mul_valid) overlap++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic run_op(input logic [15:0] act, input logic [7:0] w,
                        output int nvalid, output logic [7:0] bits,
                        output int ov_off, output int act_bad);
    bit acc;
    nvalid = 0; bits = 8'h00; ov_off = 0; act_bad = 0; acc = 0;
    in_act = act; in_weight = w; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready === 1'b1) begin
        acc = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      ov_off = -1;
      return;
    end
    for (int n = 1; n <= 40; n++) begin
      if (mul_valid === 1'b1) begin
        nvalid++;
        bits = {bits[6:0], mul_w};
        if (mul_act !== act) act_bad++;
      end
      if (out_valid === 1'b1) begin
        ov_off = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mul_valid, mul_set, out_valid, busy, cfg_ready, in_ready, out_err, mul_w} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {mul_valid, mul_set, out_valid, busy, cfg_ready, in_ready, out_err, mul_w});
    end
    checks++;
    if ({mul_act, out_exp, out_mantissa, out_sign, out_zero, out_nar} !== 38'h0) begin
      failures++;
      $display("FAIL reset_data: got act=%h exp=%h man=%h, required all 0", mul_act, out_exp, out_mantissa);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mul_set !== 1'b1 || mul_precision !== 4'd8 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_config: got set=%b prec=%0d in_ready=%b, required 1 8 0", mul_set, mul_precision, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (mul_set !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got set=%b in_ready=%b busy=%b, required 0 1 0", mul_set, in_ready, busy);
    end
  endtask

  task automatic test_cfg(input logic [3:0] req, input logic [3:0] exp_p);
    cfg_valid = 1'b1; cfg_precision = req;
    #1;
    checks++;
    if (in_ready !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL cfg_ready_%0d: got in_ready=%b cfg_ready=%b, required 0 1", req, in_ready, cfg_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    checks++;
    if (mul_set !== 1'b1 || mul_precision !== exp_p || mul_valid !== 1'b0) begin
      failures++;
      $display("FAIL cfg_pulse_%0d: got set=%b prec=%0d valid=%b, required 1 %0d 0", req, mul_set, mul_precision, mul_valid, exp_p);
    end
    @(posedge clk); #1;
    checks++;
    if (mul_set !== 1'b0 || in_ready !== 1'b1 || mul_precision !== exp_p) begin
      failures++;
      $display("FAIL cfg_after_%0d: got set=%b in_ready=%b prec=%0d, required 0 1 %0d", req, mul_set, in_ready, mul_precision, exp_p);
    end
  endtask

  task automatic test_single();
    int nv, ov, ab;
    logic [7:0] b;
    run_op(16'h3C00, 8'b0100_0000, nv, b, ov, ab);
    checks++;
    if (nv !== 8 || b !== 8'h40 || ab !== 0) begin
      failures++;
      $display("FAIL single_stream: got cycles=%0d bits=%h act_bad=%0d, required 8 40 0", nv, b, ab);
    end
    checks++;
    if (ov !== 11) begin
      failures++;
      $display("FAIL single_latency: got out_valid offset %0d, required 11", ov);
    end
    checks++;
    if (out_exp !== 5'd15 || out_mantissa !== 14'h0400 || out_sign !== 1'b0 || out_err !== 1'b0
        || out_zero !== 1'b0 || out_nar !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_data: got s=%b e=%0d m=%h err=%b z=%b n=%b in_ready=%b, required 0 15 0400 0 0 0 0",
               out_sign, out_exp, out_mantissa, out_err, out_zero, out_nar, in_ready);
    end
    mul_exp = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_exp !== 5'd15) begin
      failures++;
      $display("FAIL single_hold: got valid=%b exp=%0d, required 1 15", out_valid, out_exp);
    end
    mul_exp = 5'd15;
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_release: got valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] mv, ovm, ir, mv_exp, ov_exp, ir_exp;
    logic [7:0]  bits;
    logic [15:0] act2;
    mv = '0; ovm = '0; ir = '0; bits = 8'h00; act2 = 16'h0;
    mv_exp = 17'h01E1E; ov_exp = 17'h08080; ir_exp = 17'h10100;
    out_ready = 1'b1;
    in_act = 16'h4200; in_weight = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 16; n++) begin
      mv[n] = mul_valid; ovm[n] = out_valid; ir[n] = in_ready;
      if (mul_valid === 1'b1) bits = {bits[6:0], mul_w};
      if (n == 10) act2 = mul_act;
      if (n == 1) begin
        in_act = 16'h4400; in_weight = 8'hFA;
      end
      if (n == 9) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++;
    if (mv !== mv_exp) begin
      failures++;
      $display("FAIL b2b_mul_valid: got %h, required %h", mv, mv_exp);
    end
    checks++;
    if (ovm !== ov_exp) begin
      failures++;
      $display("FAIL b2b_out_valid: got %h, required %h", ovm, ov_exp);
    end
    checks++;
    if (ir !== ir_exp) begin
      failures++;
      $display("FAIL b2b_in_ready: got %h, required %h", ir, ir_exp);
    end
    checks++;
    if (bits !== 8'h5A || act2 !== 16'h4400) begin
      failures++;
      $display("FAIL b2b_data: got bits=%h act=%h, required 5a 4400", bits, act2);
    end
  endtask

  task automatic test_timeout();
    int nv, ov, ab;
    logic [7:0] b;
    model_en = 1'b0;
    mul_sign = 1'b1; mul_zero = 1'b1; mul_nar = 1'b1; mul_exp = 5'd31; mul_mantissa = 14'h3FFF;
    run_op(16'h4000, 8'h0C, nv, b, ov, ab);
    checks++;
    if (nv !== 4 || b !== 8'h0C || ov !== 21) begin
      failures++;
      $display("FAIL timeout_timing: got cycles=%0d bits=%h offset=%0d, required 4 0c 21", nv, b, ov);
    end
    checks++;
    if (out_err !== 1'b1 || out_sign !== 1'b0 || out_exp !== 5'd0 || out_mantissa !== 14'h0
        || out_zero !== 1'b0 || out_nar !== 1'b0) begin
      failures++;
      $display("FAIL timeout_data: got err=%b s=%b e=%0d m=%h z=%b n=%b, required 1 0 0 0 0 0",
               out_err, out_sign, out_exp, out_mantissa, out_zero, out_nar);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: got valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    end
    mul_sign = 1'b0; mul_zero = 1'b0; mul_nar = 1'b0; mul_exp = 5'd15; mul_mantissa = 14'h0400;
    model_en = 1'b1;
  endtask

  task automatic test_priority();
    int nv, ov, ab;
    logic [7:0] b;
    cfg_valid = 1'b1; cfg_precision = 4'd3;
    in_act = 16'hBC00; in_weight = 8'h06; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL prio_in_ready: got %b, required 0", in_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    checks++;
    if (mul_set !== 1'b1 || mul_precision !== 4'd3 || mul_valid !== 1'b0) begin
      failures++;
      $display("FAIL prio_config: got set=%b prec=%0d valid=%b, required 1 3 0", mul_set, mul_precision, mul_valid);
    end
    run_op(16'hBC00, 8'h06, nv, b, ov, ab);
    checks++;
    if (nv !== 3 || b !== 8'h06 || ov !== 6 || ab !== 0) begin
      failures++;
      $display("FAIL prio_stream: got cycles=%0d bits=%h offset=%0d act_bad=%0d, required 3 06 6 0", nv, b, ov, ab);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    int ovc, mvc;
    ovc = 0; mvc = 0;
    model_en = 1'b0;
    in_act = 16'h3C00; in_weight = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mul_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_streaming: got mul_valid=%b, required 1", mul_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mul_valid, mul_set, out_valid, busy, cfg_ready, in_ready, mul_w} !== 7'h00 || mul_act !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset: got ctrl=%b act=%h, required 0000000 0000",
               {mul_valid, mul_set, out_valid, busy, cfg_ready, in_ready, mul_w}, mul_act);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (mul_set !== 1'b1 || mul_precision !== 4'd8) begin
      failures++;
      $display("FAIL mid_config: got set=%b prec=%0d, required 1 8", mul_set, mul_precision);
    end
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) ovc++;
      if (mul_valid === 1'b1) mvc++;
    end
    checks++;
    if (ovc !== 0 || mvc !== 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_dropped: got out_valid=%0d mul_valid=%0d in_ready=%b, required 0 0 1", ovc, mvc, in_ready);
    end
    model_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_precision = 4'd0;
    in_valid = 1'b0; in_act = 16'h0; in_weight = 8'h0; out_ready = 1'b0;
    mul_sign = 1'b0; mul_exp = 5'd15; mul_mantissa = 14'h0400; mul_zero = 1'b0; mul_nar = 1'b0;
    test_reset();
    test_cfg(4'd5, 4'd5);
    test_cfg(4'd12, 4'd8);
    test_single();
    test_cfg(4'd4, 4'd4);
    test_back_to_back();
    test_timeout();
    test_priority();
    test_cfg(4'd0, 4'd2);
    test_cfg(4'd8, 4'd8);
    test_reset_mid();
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL set_valid_overlap: got %0d overlapping cycles, required 0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
